ext_pipe: RTL and testbench
===========================

Name: ext_pipe

Overview:
- Parametrised, registered extension stage for the p7 MIPS datapath.
- Handles immediate extension (sign, zero, lui) and load-data extension (lb/lbu/lh/lhu/lw) with byte-lane selection.
- Flags misaligned loads with the AdEL exception code.
- Sits between the memory/decode sources and the writeback/ALU consumers behind a valid/ready handshake, with a 2-entry skid buffer so back-pressure never drops data.

Parameters:
- DATA_W, 32, datapath width; must be a multiple of 8 and >= 2*IMM_W.
- IMM_W, 16, immediate field width.
- EXC_W, 5, exception code width.
- EXC_ADEL, 5'd4, code emitted on a misaligned load.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all buffered entries (exception/eret).
- in_valid  input  1  input beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- op  input  3  mode: 000 sext imm, 001 zext imm, 010 lui, 011 lb, 100 lbu, 101 lh, 110 lhu, 111 lw.
- imm  input  IMM_W  immediate field.
- rdata  input  DATA_W  raw memory word.
- addr_lo  input  2  byte offset of the load address.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- result  output  DATA_W  extended value.
- exc  output  1  result carries an exception.
- exc_code  output  EXC_W  exception code; 0 when exc=0.

Behaviour:
- Reset (reset=0, asynchronous): both buffer entries invalid; out_valid=0, result=0, exc=0, exc_code=0; in_ready=1 from the first edge after release.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Latency is exactly 1 cycle: a beat accepted at edge N is presented from edge N+1.
  - Throughput is one beat per cycle while out_ready=1.
- Buffer: 2-entry FIFO (main + skid).
  - in_ready = (count < 2), registered from state; no combinational path from out_ready.
  - States: EMPTY (count 0), ONE (count 1), FULL (count 2).
  - EMPTY -> ONE on accept.
  - ONE stays ONE on simultaneous accept and drain; ONE -> FULL on accept without drain; ONE -> EMPTY on drain without accept.
  - FULL -> ONE on drain; no accept is possible in FULL.
  - Order is strictly FIFO. out_valid/result/exc must stay stable while out_valid && !out_ready.
- Compute (combinational, before the buffer write):
  - sext: {(DATA_W-IMM_W){imm[IMM_W-1]}, imm}.
  - zext: zero-filled.
  - lui: imm placed in the top IMM_W bits, low bits 0.
  - lb/lbu: byte lane addr_lo selected (lane 0 = rdata[7:0], little-endian), then sign- or zero-extended.
  - lh/lhu: half lane addr_lo[1] selected, then sign- or zero-extended.
  - lw: rdata passed through.
  - Immediate modes ignore addr_lo.
- Alignment:
  - lh/lhu with addr_lo[0]=1, or lw with addr_lo != 0: exc=1, exc_code=EXC_ADEL, result=0.
  - Byte loads never fault.
- Flush:
  - The flush edge invalidates both entries (count 0); out_valid=0 next cycle.
  - A beat offered in the flush cycle is discarded even if in_ready=1.
  - Flush has priority over accept and drain.
- Reset mid-transfer: in-flight entries are lost; no partial output.

Test Plan:
- Immediate modes, out_ready=1:
  - imm=16'h8001: sext -> 32'hFFFF8001.
  - zext -> 32'h00008001.
  - lui -> 32'h80010000.
  - Each appears exactly one cycle after acceptance.
- Load lanes with rdata=32'h80F17F22:
  - lb addr_lo=1 -> 32'h0000007F.
  - lb addr_lo=3 -> 32'hFFFFFF80.
  - lbu addr_lo=2 -> 32'h000000F1.
  - lh addr_lo=2 -> 32'hFFFF80F1.
  - lhu addr_lo=0 -> 32'h00007F22.
- Misalignment:
  - lw addr_lo=2 -> exc=1, exc_code=4, result=0.
  - lh addr_lo=3 -> same.
  - lbu addr_lo=3 -> exc=0.
- Back-pressure: stream 4 lui beats (imm 1..4) with out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepts.
  - Output holds 32'h00010000 stably.
  - On release, results drain in order 1,2,3,4 with no loss or duplication.
- Flush with count=2 plus a beat offered the same cycle:
  - Next cycle out_valid=0, in_ready=1.
  - The flushed beat never appears.
- Assert reset while count=1 mid-cycle:
  - Outputs zero immediately, asynchronously.
  - After release the stage accepts and returns a sext result correctly.

Source files
------------

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate / load-data extension stage for the p7 datapath.
// One beat of combinational extension feeds a 2-entry FIFO (head + skid).
// in_ready is registered from the next FIFO state, so out_ready has no
// combinational path to in_ready.
module ext_pipe #(
   parameter int                DATA_W   = 32,
   parameter int                IMM_W    = 16,
   parameter int                EXC_W    = 5,
   parameter logic [EXC_W-1:0]  EXC_ADEL = EXC_W'(4)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic [IMM_W-1:0]  imm,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        addr_lo,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              exc,
   output logic [EXC_W-1:0]  exc_code
);

   // One buffered entry: {exc, result}
   localparam int ENT_W = DATA_W + 1;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t             state_reg, state_next;
   logic               in_ready_reg;
   logic [ENT_W-1:0]   head_reg, skid_reg;
   logic               load_head, load_skid, shift_skid;
   logic               accept, drain;

   logic [7:0]         byte_lane;
   logic [15:0]        half_lane;
   logic [DATA_W-1:0]  calc_result;
   logic               calc_misalign;

   // Lane selection: little-endian, byte lane addr_lo, half lane addr_lo[1]
   assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
   assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

   // Extension datapath; misaligned half/word loads produce a zero result
   always_comb begin
      calc_result   = '0;
      calc_misalign = 1'b0;
      case (op)
         3'b000: calc_result = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
         3'b001: calc_result = {{(DATA_W-IMM_W){1'b0}}, imm};
         3'b010: calc_result = {imm, {(DATA_W-IMM_W){1'b0}}};
         3'b011: calc_result = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
         3'b100: calc_result = {{(DATA_W-8){1'b0}}, byte_lane};
         3'b101: begin
            calc_result   = {{(DATA_W-16){half_lane[15]}}, half_lane};
            calc_misalign = addr_lo[0];
         end
         3'b110: begin
            calc_result   = {{(DATA_W-16){1'b0}}, half_lane};
            calc_misalign = addr_lo[0];
         end
         default: begin
            calc_result   = rdata;
            calc_misalign = (addr_lo != 2'b00);
         end
      endcase
      if (calc_misalign)
         calc_result = '0;
   end

   assign accept = in_valid && in_ready_reg;
   assign drain  = (state_reg != EMPTY) && out_ready;

   // FIFO control: flush wins over accept and drain
   always_comb begin
      state_next = state_reg;
      load_head  = 1'b0;
      load_skid  = 1'b0;
      shift_skid = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (accept) begin
                  state_next = ONE;
                  load_head  = 1'b1;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  load_head = 1'b1;
               end else if (accept) begin
                  state_next = FULL;
                  load_skid  = 1'b1;
               end else if (drain) begin
                  state_next = EMPTY;
               end
            end
            FULL: begin
               if (drain) begin
                  state_next = ONE;
                  shift_skid = 1'b1;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   // State register; in_ready follows the state being entered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= EMPTY;
         in_ready_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         in_ready_reg <= (state_next != FULL);
      end
   end

   // Entry storage: head is what the consumer sees, skid holds the second beat
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_reg <= '0;
         skid_reg <= '0;
      end else begin
         if (load_head)
            head_reg <= {calc_misalign, calc_result};
         else if (shift_skid)
            head_reg <= skid_reg;
         if (load_skid)
            skid_reg <= {calc_misalign, calc_result};
      end
   end

   // Outputs are gated by validity so an empty stage always presents zeros
   assign in_ready  = in_ready_reg;
   assign out_valid = (state_reg != EMPTY);
   assign result    = out_valid ? head_reg[DATA_W-1:0] : '0;
   assign exc       = out_valid & head_reg[DATA_W];
   assign exc_code  = exc ? EXC_ADEL : '0;

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed vectors for ext_pipe with hand-computed expectations.
module tb_ext_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = 3'b000;
   logic [15:0] imm = '0;
   logic [31:0] rdata = '0;
   logic [1:0]  addr_lo = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        exc;
   logic [4:0]  exc_code;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0] OP_SEXT = 3'b000, OP_ZEXT = 3'b001, OP_LUI = 3'b010,
                          OP_LB = 3'b011, OP_LBU = 3'b100, OP_LH = 3'b101,
                          OP_LHU = 3'b110, OP_LW = 3'b111;
   localparam logic [31:0] RD = 32'h80F17F22;

   always #5 clk = ~clk;

   ext_pipe dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .imm(imm), .rdata(rdata), .addr_lo(addr_lo),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .exc(exc), .exc_code(exc_code)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   // Called at a negedge with the stage empty; checks one-cycle latency and drain
   task automatic send(input string tag, input logic [2:0] o, input logic [15:0] im,
                       input logic [31:0] rd, input logic [1:0] al,
                       input logic [31:0] er, input logic ee);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; op = o; imm = im; rdata = rd; addr_lo = al; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_result"}, result, er);
      check({tag, "_exc"}, 32'(exc), 32'(ee));
      check({tag, "_code"}, 32'(exc_code), ee ? 32'd4 : 32'd0);
      @(posedge clk); @(negedge clk);
      check({tag, "_drained"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      // Asynchronous reset with no clock edge yet
      #1 reset = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_exc", 32'(exc), 32'd0);
      check("rst_code", 32'(exc_code), 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      check("rel_in_ready", 32'(in_ready), 32'd1);

      // Immediate modes
      send("sext", OP_SEXT, 16'h8001, RD, 2'd0, 32'hFFFF8001, 1'b0);
      send("zext", OP_ZEXT, 16'h8001, RD, 2'd0, 32'h00008001, 1'b0);
      send("lui",  OP_LUI,  16'h8001, RD, 2'd0, 32'h80010000, 1'b0);
      send("sext_al3", OP_SEXT, 16'h8001, RD, 2'd3, 32'hFFFF8001, 1'b0);

      // Load lanes
      send("lb1",  OP_LB,  16'h0, RD, 2'd1, 32'h0000007F, 1'b0);
      send("lb3",  OP_LB,  16'h0, RD, 2'd3, 32'hFFFFFF80, 1'b0);
      send("lbu2", OP_LBU, 16'h0, RD, 2'd2, 32'h000000F1, 1'b0);
      send("lh2",  OP_LH,  16'h0, RD, 2'd2, 32'hFFFF80F1, 1'b0);
      send("lhu0", OP_LHU, 16'h0, RD, 2'd0, 32'h00007F22, 1'b0);
      send("lw0",  OP_LW,  16'h0, RD, 2'd0, 32'h80F17F22, 1'b0);

      // Misalignment
      send("lw2",  OP_LW,  16'h0, RD, 2'd2, 32'h0, 1'b1);
      send("lh3",  OP_LH,  16'h0, RD, 2'd3, 32'h0, 1'b1);
      send("lhu1", OP_LHU, 16'h0, RD, 2'd1, 32'h0, 1'b1);
      send("lbu3", OP_LBU, 16'h0, RD, 2'd3, 32'h00000080, 1'b0);

      // Back-pressure: lui 1..4 with out_ready low for three cycles
      out_ready = 1'b0; in_valid = 1'b1; op = OP_LUI; imm = 16'd1; addr_lo = 2'd0;
      @(posedge clk); @(negedge clk);
      check("bp1_valid", 32'(out_valid), 32'd1);
      check("bp1_result", result, 32'h00010000);
      check("bp1_in_ready", 32'(in_ready), 32'd1);
      imm = 16'd2;
      @(posedge clk); @(negedge clk);
      check("bp2_result", result, 32'h00010000);
      check("bp2_in_ready", 32'(in_ready), 32'd0);
      imm = 16'd3;
      @(posedge clk); @(negedge clk);
      check("bp3_result", result, 32'h00010000);
      check("bp3_valid", 32'(out_valid), 32'd1);
      check("bp3_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("dr_a_result", result, 32'h00020000);
      check("dr_a_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      check("dr_b_result", result, 32'h00030000);
      imm = 16'd4;
      @(posedge clk); @(negedge clk);
      check("dr_c_result", result, 32'h00040000);
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check("dr_empty", 32'(out_valid), 32'd0);

      // Flush with both entries full and a beat offered the same cycle
      out_ready = 1'b0; in_valid = 1'b1; op = OP_SEXT; imm = 16'h0011;
      @(posedge clk); @(negedge clk);
      imm = 16'h0022;
      @(posedge clk); @(negedge clk);
      check("fl_full", 32'(in_ready), 32'd0);
      flush = 1'b1; imm = 16'h0033;
      @(posedge clk); @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("fl_valid", 32'(out_valid), 32'd0);
      check("fl_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      check("fl_none", 32'(out_valid), 32'd0);

      // Flush while empty: the offered beat is dropped even with in_ready high
      in_valid = 1'b1; flush = 1'b1; imm = 16'h0044;
      @(posedge clk); @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("fl0_valid", 32'(out_valid), 32'd0);
      check("fl0_result", result, 32'd0);

      // Asynchronous reset with one faulting entry held
      out_ready = 1'b0; in_valid = 1'b1; op = OP_LW; addr_lo = 2'd1; imm = 16'h0;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      check("ar_pre_valid", 32'(out_valid), 32'd1);
      check("ar_pre_exc", 32'(exc), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("ar_valid", 32'(out_valid), 32'd0);
      check("ar_exc", 32'(exc), 32'd0);
      check("ar_code", 32'(exc_code), 32'd0);
      check("ar_result", result, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      send("post_rst", OP_SEXT, 16'hFFFE, RD, 2'd0, 32'hFFFFFFFE, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
